hline_burst_master: RTL and testbench

- Bus-side responder for the hline z-buffer sequencer.
- Accepts one read or write burst request at a time and runs it on a simple split command/data burst memory interface.
- Read data is pushed into the z-read FIFO. Write data and byte-enables are popped from the z-out FIFO and the byte-enable FIFO.
- Signals completion with a one-cycle done pulse that the sequencer polls.

---
 rtl/hline_pkg.sv | 30 +++
 rtl/hline_beat_counter.sv | 34 +++
 rtl/hline_burst_master.sv | 201 ++++++++++++++++++++
 tb/tb_hline_burst_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hline_pkg.sv
// Shared definitions for the hline z-buffer sequencer and its burst master:
// state encoding, default widths and request direction constants.
package hline_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 256;
  localparam int DEF_LEN_W     = 9;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_CMD  = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_CMD  = 3'd3;
  localparam logic [2:0] ST_WR_DATA = 3'd4;
  localparam logic [2:0] ST_WR_RESP = 3'd5;
  localparam logic [2:0] ST_FIN     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_CMD  = ST_RD_CMD,
    S_RD_DATA = ST_RD_DATA,
    S_WR_CMD  = ST_WR_CMD,
    S_WR_DATA = ST_WR_DATA,
    S_WR_RESP = ST_WR_RESP,
    S_FIN     = ST_FIN
  } burst_state_t;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/hline_beat_counter.sv
// Beat counter for one burst: cleared and loaded with the burst length at
// request acceptance, stepped once per transferred beat.
module hline_beat_counter
  import hline_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             inc,
  output logic             last_beat
);

  logic [LEN_W:0]   count;
  logic [LEN_W-1:0] len_q;

  // One extra bit so the count can sit at len without wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      len_q <= '0;
    end else if (load) begin
      count <= '0;
      len_q <= len;
    end else if (inc && (count != {1'b0, len_q})) begin
      count <= count + 1'b1;
    end
  end

  assign last_beat = ((count + 1'b1) == {1'b0, len_q});

endmodule

// File: rtl/hline_burst_master.sv
// Burst master for the hline z-buffer sequencer: runs one read or write burst
// at a time. Optional stall timeout enabled by HLINE_BURST_TIMEOUT_EN.
module hline_burst_master
  import hline_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int LEN_W     = DEF_LEN_W
`ifdef HLINE_BURST_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [31:0]         req_addr,
  input  logic [LEN_W-1:0]    req_len,
  output logic                done,
  output logic                busy,
  output logic                err,
  output logic                zfifo_wr,
  output logic [DATA_W-1:0]   zfifo_data,
  input  logic                zfifo_full,
  output logic                wdata_rd,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                wdata_empty,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic                mem_cmd_write,
  output logic [31:0]         mem_cmd_addr,
  output logic [LEN_W-1:0]    mem_cmd_len,
  input  logic                mem_rd_valid,
  output logic                mem_rd_ready,
  input  logic [DATA_W-1:0]   mem_rd_data,
  input  logic                mem_rd_last,
  output logic                mem_wr_valid,
  input  logic                mem_wr_ready,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_be,
  output logic                mem_wr_last,
  input  logic                mem_wr_resp
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  burst_state_t     state;
  logic             armed;
  logic             err_flag;
  logic             draining;
  logic             timeout_hit;
  logic             last_beat;
  logic             accept;
  logic             rd_beat;
  logic             wr_beat;
  logic             rd_mismatch;
  logic [LEN_W-1:0] clamped_len;

  assign clamped_len = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  assign accept      = (state == S_IDLE) && armed && !draining && (rd_req || wr_req);

  assign busy         = (state != S_IDLE);
  assign mem_rd_ready = ((state == S_RD_DATA) && !zfifo_full) || draining;
  assign rd_beat      = (state == S_RD_DATA) && mem_rd_valid && !zfifo_full;
  assign rd_mismatch  = rd_beat && (mem_rd_last != last_beat);
  assign zfifo_wr     = rd_beat;
  assign zfifo_data   = (state == S_RD_DATA) ? mem_rd_data : '0;

  assign mem_wr_valid = (state == S_WR_DATA) && !wdata_empty;
  assign mem_wr_data  = (state == S_WR_DATA) ? wdata : '0;
  assign mem_wr_be    = (state == S_WR_DATA) ? wbe : '0;
  assign mem_wr_last  = mem_wr_valid && last_beat;
  assign wr_beat      = mem_wr_valid && mem_wr_ready;
  assign wdata_rd     = wr_beat;

  hline_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .len       (clamped_len),
    .inc       (rd_beat || wr_beat),
    .last_beat (last_beat)
  );

`ifdef HLINE_BURST_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall;
  logic               progress;

  assign progress    = (mem_cmd_valid && mem_cmd_ready) || rd_beat || wr_beat ||
                       ((state == S_WR_RESP) && mem_wr_resp);
  assign timeout_hit = (state != S_IDLE) && (state != S_FIN) && !progress &&
                       (stall == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall <= '0;
    end else if ((state == S_IDLE) || (state == S_FIN) || progress) begin
      stall <= '0;
    end else begin
      stall <= stall + 1'b1;
    end
  end

  // Beats still in flight after an aborted read are swallowed up to mem_rd_last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      draining <= 1'b0;
    end else if (timeout_hit && (state == S_RD_DATA)) begin
      draining <= 1'b1;
    end else if (draining && mem_rd_valid && mem_rd_last) begin
      draining <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign draining    = 1'b0;
`endif

  // done/err are registered on entry to FIN so they coincide with that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      armed         <= 1'b1;
      err_flag      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_len   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!rd_req && !wr_req) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            armed         <= 1'b0;
            err_flag      <= 1'b0;
            mem_cmd_addr  <= req_addr & ~32'h3;
            mem_cmd_len   <= clamped_len;
            mem_cmd_write <= rd_req ? DIR_RD : DIR_WR;
            if (clamped_len == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state         <= rd_req ? S_RD_CMD : S_WR_CMD;
              mem_cmd_valid <= 1'b1;
            end
          end
        end
        S_RD_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rd_mismatch) err_flag <= 1'b1;
          if (rd_beat && last_beat) begin
            state <= S_FIN;
            done  <= 1'b1;
            err   <= err_flag || rd_mismatch;
          end
        end
        S_WR_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (wr_beat && last_beat) state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (mem_wr_resp) begin
            state <= S_FIN;
            done  <= 1'b1;
            err   <= err_flag;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (timeout_hit) begin
        state         <= S_FIN;
        done          <= 1'b1;
        err           <= 1'b1;
        mem_cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hline_burst_master.sv
// Scoreboard bench for hline_burst_master; the timeout case runs only when
// HLINE_BURST_TIMEOUT_EN is defined (TIMEOUT = 16).
module tb_hline_burst_master;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 9;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_req, wr_req;
  logic [31:0]       req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              done, busy, err;
  logic              zfifo_wr;
  logic [DATA_W-1:0] zfifo_data;
  logic              zfifo_full;
  logic              wdata_rd;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   wbe;
  logic              wdata_empty;
  logic              mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [31:0]       mem_cmd_addr;
  logic [LEN_W-1:0]  mem_cmd_len;
  logic              mem_rd_valid, mem_rd_ready, mem_rd_last;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_valid, mem_wr_ready, mem_wr_last, mem_wr_resp;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_wr_be;

  int checks   = 0;
  int failures = 0;

  logic [41:0] exp_cmd[$];
  logic [31:0] exp_push[$];
  logic [36:0] exp_wr[$];
  logic        exp_done[$];

  always #5 clk = ~clk;

  hline_burst_master #(
    .DATA_W(DATA_W), .MAX_BURST(256), .LEN_W(LEN_W)
`ifdef HLINE_BURST_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
    .req_addr(req_addr), .req_len(req_len), .done(done), .busy(busy), .err(err),
    .zfifo_wr(zfifo_wr), .zfifo_data(zfifo_data), .zfifo_full(zfifo_full),
    .wdata_rd(wdata_rd), .wdata(wdata), .wbe(wbe), .wdata_empty(wdata_empty),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .mem_rd_last(mem_rd_last), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be), .mem_wr_last(mem_wr_last),
    .mem_wr_resp(mem_wr_resp)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic flagUnexpected(input string name, input logic [63:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=0x%0h expected=none", name, actual);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (exp_cmd.size() == 0) flagUnexpected("cmd", {mem_cmd_write, mem_cmd_addr, mem_cmd_len});
        else checkOutput("cmd", {mem_cmd_write, mem_cmd_addr, mem_cmd_len}, exp_cmd.pop_front());
      end
      if (zfifo_wr) begin
        if (exp_push.size() == 0) flagUnexpected("zfifo_push", zfifo_data);
        else checkOutput("zfifo_push", zfifo_data, exp_push.pop_front());
      end
      if (mem_wr_valid && mem_wr_ready) begin
        if (exp_wr.size() == 0) flagUnexpected("wr_beat", {mem_wr_data, mem_wr_be, mem_wr_last});
        else checkOutput("wr_beat", {mem_wr_data, mem_wr_be, mem_wr_last}, exp_wr.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) flagUnexpected("done", err);
        else checkOutput("done_err", err, exp_done.pop_front());
      end
      if (err && !done) flagUnexpected("err_without_done", err);
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [LEN_W-1:0] len);
    rd_req = rd; wr_req = wr; req_addr = addr; req_len = len;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic sendRdBeat(input logic [31:0] d, input logic last);
    logic hs;
    int   n;
    hs = 1'b0; n = 0;
    mem_rd_valid = 1'b1; mem_rd_data = d; mem_rd_last = last;
    while (!hs && n < 64) begin
      @(negedge clk); hs = mem_rd_ready;
      @(posedge clk); #1;
      n++;
    end
    mem_rd_valid = 1'b0; mem_rd_last = 1'b0;
    if (!hs) flagUnexpected("rd_beat_timeout", d);
  endtask

  task automatic runWrBeats(input int stop_at);
    int   idx, cyc;
    logic pop;
    idx = 0; cyc = 0;
    while (idx < stop_at && cyc < 4000) begin
      wdata       = 32'hC000_0000 + 32'(idx);
      wbe         = idx[0] ? 4'h0 : 4'hF;
      wdata_empty = (cyc % 3 == 2);
      @(negedge clk); pop = wdata_rd;
      @(posedge clk); #1;
      if (pop) idx++;
      cyc++;
    end
    wdata_empty = 1'b1;
    if (idx != stop_at) flagUnexpected("wr_beats_timeout", idx);
  endtask

  task automatic waitDoneNow(input string name);
    @(negedge clk); checkOutput(name, done, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; rd_req = 0; wr_req = 0; req_addr = '0; req_len = '0;
    zfifo_full = 0; wdata = '0; wbe = '0; wdata_empty = 1'b1;
    mem_cmd_ready = 1'b1; mem_rd_valid = 0; mem_rd_data = '0; mem_rd_last = 0;
    mem_wr_ready = 1'b1; mem_wr_resp = 0;

    @(negedge clk);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cmd_valid", mem_cmd_valid, 0);
    checkOutput("reset_rd_ready", mem_rd_ready, 0);
    checkOutput("reset_wr_valid", mem_wr_valid, 0);
    checkOutput("reset_cmd_addr", mem_cmd_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Read len 4, unaligned address.
    exp_cmd.push_back({1'b0, 32'h1000_0000, 9'd4});
    for (int i = 0; i < 4; i++) exp_push.push_back(32'hA + 32'(i));
    exp_done.push_back(1'b0);
    applyStimulus(1'b1, 1'b0, 32'h1000_0003, 9'd4);
    for (int i = 0; i < 4; i++) sendRdBeat(32'hA + 32'(i), i == 3);
    waitDoneNow("rd4_done_timing");

    // Read len 8 with the z-read FIFO full for three cycles mid-burst.
    exp_cmd.push_back({1'b0, 32'h0000_1100, 9'd8});
    for (int i = 0; i < 8; i++) exp_push.push_back(32'h100 + 32'(i));
    exp_done.push_back(1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_1100, 9'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        zfifo_full = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 32'h102; mem_rd_last = 1'b0;
        repeat (3) begin
          @(negedge clk); checkOutput("full_rd_ready_low", mem_rd_ready, 0);
          @(posedge clk); #1;
        end
        zfifo_full = 1'b0;
      end
      sendRdBeat(32'h100 + 32'(i), i == 7);
    end
    waitDoneNow("rd8_done_timing");

    // Write len 256, alternating strobes, FIFO empty every third cycle.
    exp_cmd.push_back({1'b1, 32'h0000_2000, 9'd256});
    for (int i = 0; i < 256; i++)
      exp_wr.push_back({32'hC000_0000 + 32'(i), (i % 2 == 1) ? 4'h0 : 4'hF, i == 255});
    exp_done.push_back(1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_2000, 9'd256);
    runWrBeats(256);
    repeat (2) begin
      @(negedge clk); checkOutput("wr_resp_wait_busy", busy, 1);
      @(posedge clk); #1;
    end
    mem_wr_resp = 1'b1;
    @(posedge clk); #1;
    mem_wr_resp = 1'b0;
    waitDoneNow("wr256_done_timing");

    // Read len 3 with mem_rd_last on the wrong beat: err expected.
    exp_cmd.push_back({1'b0, 32'h0000_5000, 9'd3});
    for (int i = 0; i < 3; i++) exp_push.push_back(32'h61 + 32'(i));
    exp_done.push_back(1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_5000, 9'd3);
    for (int i = 0; i < 3; i++) sendRdBeat(32'h61 + 32'(i), i == 1);
    waitDoneNow("rd_mismatch_done");

    // Both requests together and held: one read only.
    exp_cmd.push_back({1'b0, 32'h0000_2000, 9'd2});
    exp_push.push_back(32'h71); exp_push.push_back(32'h72);
    exp_done.push_back(1'b0);
    rd_req = 1'b1; wr_req = 1'b1; req_addr = 32'h0000_2000; req_len = 9'd2;
    @(posedge clk); #1;
    sendRdBeat(32'h71, 1'b0);
    sendRdBeat(32'h72, 1'b1);
    waitDoneNow("held_done");
    repeat (4) begin
      @(negedge clk); checkOutput("held_no_restart", busy, 0);
      @(posedge clk); #1;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1;

    // Zero length: done on the second cycle, no command.
    exp_done.push_back(1'b0);
    rd_req = 1'b1; req_addr = 32'h0000_6000; req_len = 9'd0;
    @(negedge clk); checkOutput("len0_done_cycle1", done, 0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk); checkOutput("len0_done_cycle2", done, 1);
    @(posedge clk); #1;

    // Reset in the middle of a write burst.
    exp_cmd.push_back({1'b1, 32'h0000_3000, 9'd200});
    for (int i = 0; i < 200; i++)
      exp_wr.push_back({32'hC000_0000 + 32'(i), (i % 2 == 1) ? 4'h0 : 4'hF, i == 199});
    applyStimulus(1'b0, 1'b1, 32'h0000_3000, 9'd200);
    runWrBeats(100);
    wdata = 32'hC000_0000 + 32'd100; wbe = 4'hF; wdata_empty = 1'b0;
    #1 checkOutput("midwr_valid_before_reset", mem_wr_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("midwr_reset_wr_valid", mem_wr_valid, 0);
    checkOutput("midwr_reset_wdata_rd", wdata_rd, 0);
    checkOutput("midwr_reset_busy", busy, 0);
    checkOutput("midwr_reset_wr_data", mem_wr_data, 0);
    checkOutput("midwr_reset_cmd_addr", mem_cmd_addr, 0);
    exp_wr.delete();
    wdata_empty = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    exp_cmd.push_back({1'b0, 32'h0000_4000, 9'd1});
    exp_push.push_back(32'h55);
    exp_done.push_back(1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 9'd1);
    sendRdBeat(32'h55, 1'b1);
    waitDoneNow("post_reset_done");

`ifdef HLINE_BURST_TIMEOUT_EN
    // Command never accepted: abort with err on cycle 17.
    exp_done.push_back(1'b1);
    mem_cmd_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0000_7000, 9'd4);
    repeat (15) begin @(posedge clk); #1; end
    @(negedge clk); checkOutput("timeout_done_cycle16", done, 0);
    @(posedge clk); #1;
    @(negedge clk); checkOutput("timeout_done_cycle17", done, 1);
    mem_cmd_ready = 1'b1;
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    checkOutput("exp_cmd_drained", exp_cmd.size(), 0);
    checkOutput("exp_push_drained", exp_push.size(), 0);
    checkOutput("exp_wr_drained", exp_wr.size(), 0);
    checkOutput("exp_done_drained", exp_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
